serial_adder_datapath: RTL and testbench
========================================

# serial_adder_datapath

Bit-serial adder datapath driven by the shift/load/done controller: it consumes the controller's `LD`, `SH` and `D` strobes and produces an N-bit sum one bit per shift. On `LD` it captures two parallel operands. It then adds them LSB-first through a single full adder and carry flip-flop. It presents the final sum, carry-out and a valid flag once the controller signals done.

## Interface
- `N`, default 8: operand/sum width; legal range 2..32.
- `Cin`  input  1  clock; all state updates on rising edge.
- `RST`  input  1  synchronous, active-high reset.
- `LD`  input  1  load strobe from controller; captures operands.
- `SH`  input  1  shift strobe from controller; performs one bit-add step.
- `D`  input  1  done strobe from controller; qualifies result.
- `A_IN`  input  N  operand A, sampled on `LD`.
- `B_IN`  input  N  operand B, sampled on `LD`.
- `SUB`  input  1  subtract select, sampled on `LD`; present only with `SERIAL_ADD_SUB_EN`.
- `SUM`  output  N  accumulator contents; this is the final sum after N shifts.
- `COUT`  output  1  carry flip-flop contents; this is the final carry-out after N shifts.
- `SO`  output  1  combinational sum bit for the current step: `ACC[0]^BREG[0]^CARRY`.
- `VALID`  output  1  result valid; set by `D` after exactly N shifts.
- `ERR`  output  1  sticky protocol error.

## Operation
- State: `ACC[N-1:0]`, `BREG[N-1:0]`, `CARRY`, `CNT[$clog2(N+1)-1:0]`, `VALID`, `ERR`.
- Reset (`RST=1` at edge): all state is cleared to 0. Consequently `SUM=0`, `COUT=0`, `SO=0`, `VALID=0`, `ERR=0`.
- Priority per edge: `RST` > `LD` > `SH`. `D` is evaluated alongside `SH`/idle, never alongside `LD`.
- `LD` updates:
  - `ACC<=A_IN`, `BREG<=B_IN`, `CARRY<=0`, `CNT<=0`, `VALID<=0`, `ERR<=0`.
  - `SH` is ignored in the same cycle.
- `SH` with `LD=0` and `CNT<N`:
  - s = `ACC[0]^BREG[0]^CARRY`.
  - c = majority(`ACC[0]`, `BREG[0]`, `CARRY`).
  - `ACC<={s,ACC[N-1:1]}`, `BREG<={1'b0,BREG[N-1:1]}`, `CARRY<=c`, `CNT<=CNT+1`.
- `SH` with `CNT==N`: datapath is frozen (no state change) and `ERR<=1` (overrun).
- `D=1` with `LD=0`:
  - If `CNT==N` (evaluated before any same-edge shift), then `VALID<=1`.
  - Otherwise `ERR<=1` and `VALID` is unchanged.
- `VALID` stays high until the next `LD` or `RST`. `D` held high for multiple cycles is harmless.
- Arithmetic is modulo 2^N on `SUM`. The true (N+1)-bit result is `{COUT,SUM}`.
- `SH` before any `LD` after reset shifts zeros: `SUM` stays 0 while `CNT` advances.

## Timing
- Load latency: operands are visible on `SUM` (as A) one edge after `LD`.
- Each `SH` edge retires one bit. After the Nth `SH` edge, `SUM`/`COUT` hold the final result.
- `VALID` rises on the edge that samples `D=1` with `CNT==N`. The earliest case is the edge after the Nth `SH`, giving minimum load-to-valid of N+2 edges.
- `SH` need not be contiguous. Idle cycles between shifts hold all state.
- `SO` changes combinationally after each edge. Downstream serial consumers sample it on the same edge as `SH`.
- Reset mid-operation: the next edge clears everything, and a new `LD` is required. Partial results are never flagged valid.

## Configuration
- Macro `SERIAL_ADD_SUB_EN`.
- Defined:
  - `SUB` port exists.
  - On `LD` with `SUB=1`: `BREG<=~B_IN` and `CARRY<=1`, giving `SUM=A-B` mod 2^N with `COUT=1` meaning no borrow.
  - `SUB=0` behaves exactly as addition.
- Undefined: no `SUB` port, addition only, `CARRY` always loads 0.

## Test plan
- N=8, `LD` A=0x35 B=0x4A, 8×`SH`, then `D` -> `SUM=0x7F`, `COUT=0`, `VALID=1` on the `D` edge, `ERR=0`.
- N=8, A=0xFF B=0x01, 8×`SH` with idle gaps, then `D` -> `SUM=0x00`, `COUT=1`, `VALID=1`. `SO` sequence LSB-first is 0,0,0,0,0,0,0,0.
- Overrun: after the sequence above, a 9th `SH` -> `ERR=1`, `SUM`/`COUT` unchanged. Next `LD` -> `ERR=0`, `VALID=0`.
- Early done: `LD` A=0x0F B=0x01, 4×`SH`, `D` -> `ERR=1`, `VALID=0`. `RST` mid-sequence after 3 shifts -> all outputs 0 on the next edge.
- Collision: `LD` and `SH` asserted together with A=0x12 B=0x34 -> `SUM=0x12` and `CNT=0`, i.e. the load happens with no shift.
- With `SERIAL_ADD_SUB_EN`:
  - A=0x10 B=0x01 `SUB=1`, 8×`SH`, `D` -> `SUM=0x0F`, `COUT=1`.
  - A=0x01 B=0x02 `SUB=1` -> `SUM=0xFF`, `COUT=0`.

Source files
------------

// File: rtl/serial_adder_if.sv
// Controller/datapath bundle for the bit-serial adder: strobes, operands and result.
// SUB exists only when SERIAL_ADD_SUB_EN is defined.
interface serial_adder_if #(
    parameter int unsigned N = 8
);
    logic         LD;
    logic         SH;
    logic         D;
    logic [N-1:0] A_IN;
    logic [N-1:0] B_IN;
`ifdef SERIAL_ADD_SUB_EN
    logic         SUB;
`endif
    logic [N-1:0] SUM;
    logic         COUT;
    logic         SO;
    logic         VALID;
    logic         ERR;

`ifdef SERIAL_ADD_SUB_EN
    modport master (
        output LD, SH, D, A_IN, B_IN, SUB,
        input  SUM, COUT, SO, VALID, ERR
    );
    modport slave (
        input  LD, SH, D, A_IN, B_IN, SUB,
        output SUM, COUT, SO, VALID, ERR
    );
`else
    modport master (
        output LD, SH, D, A_IN, B_IN,
        input  SUM, COUT, SO, VALID, ERR
    );
    modport slave (
        input  LD, SH, D, A_IN, B_IN,
        output SUM, COUT, SO, VALID, ERR
    );
`endif
endinterface

// File: rtl/serial_adder_datapath.sv
// Bit-serial adder datapath: loads operands on LD, retires one sum bit per SH, flags VALID on D.
// Optional subtract mode is enabled by defining SERIAL_ADD_SUB_EN.
module serial_adder_datapath #(
    parameter int unsigned N = 8
) (
    input logic           Cin,
    input logic           RST,
    serial_adder_if.slave bus
);
    localparam int unsigned CW = $clog2(N + 1);

    logic [N-1:0]  acc;
    logic [N-1:0]  breg;
    logic          carry;
    logic [CW-1:0] cnt;
    logic          valid;
    logic          err;

    logic          sum_bit;
    logic          carry_bit;
    logic          at_end;

    // Single full adder on the LSBs; carry is the majority of the three inputs.
    assign sum_bit   = acc[0] ^ breg[0] ^ carry;
    assign carry_bit = (acc[0] & breg[0]) | (acc[0] & carry) | (breg[0] & carry);
    assign at_end    = (cnt == CW'(N));

    always_ff @(posedge Cin) begin
        if (RST) begin
            acc   <= '0;
            breg  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            valid <= 1'b0;
            err   <= 1'b0;
        end else if (bus.LD) begin
            acc   <= bus.A_IN;
            cnt   <= '0;
            valid <= 1'b0;
            err   <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
            // Subtraction as A + ~B + 1: invert B and preload the carry.
            breg  <= bus.SUB ? ~bus.B_IN : bus.B_IN;
            carry <= bus.SUB;
`else
            breg  <= bus.B_IN;
            carry <= 1'b0;
`endif
        end else begin
            if (bus.SH && !at_end) begin
                acc   <= {sum_bit, acc[N-1:1]};
                breg  <= {1'b0, breg[N-1:1]};
                carry <= carry_bit;
                cnt   <= cnt + CW'(1);
            end
            // Done is judged on the pre-edge count; overrun and early done are both sticky errors.
            if (bus.D && at_end) begin
                valid <= 1'b1;
            end
            if ((bus.SH && at_end) || (bus.D && !at_end)) begin
                err <= 1'b1;
            end
        end
    end

    assign bus.SUM   = acc;
    assign bus.COUT  = carry;
    assign bus.SO    = sum_bit;
    assign bus.VALID = valid;
    assign bus.ERR   = err;
endmodule

// File: tb/tb_serial_adder_datapath.sv
// Randomized scoreboard bench for serial_adder_datapath (N=8) against an arithmetic reference model.
module tb_serial_adder_datapath;
    localparam int unsigned N = 8;

    typedef struct packed {
        logic [N-1:0] sum;
        logic         cout;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    serial_adder_if #(.N(N)) bus ();

    serial_adder_datapath #(.N(N)) dut (
        .Cin (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: the full (N+1)-bit result of A+B, or A-B as A + ~B + 1.
    function automatic logic [N:0] ref_result(input logic [N-1:0] a, input logic [N-1:0] b,
                                              input logic sub);
        logic [N-1:0] nb;
        nb = ~b;
        if (sub) return {1'b0, a} + {1'b0, nb} + (N+1)'(1);
        return {1'b0, a} + {1'b0, b};
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub,
                           input logic with_sh);
        bus.LD   = 1'b1;
        bus.SH   = with_sh;
        bus.A_IN = a;
        bus.B_IN = b;
`ifdef SERIAL_ADD_SUB_EN
        bus.SUB  = sub;
`else
        if (sub) $display("note: subtract requested without SERIAL_ADD_SUB_EN");
`endif
        cycle();
        bus.LD = 1'b0;
        bus.SH = 1'b0;
        check("load_sum", 32'(bus.SUM), 32'(a));
    endtask

    // n shift strobes starting at bit index 'first'; optionally checks SO against the reference.
    task automatic do_shifts(input int n, input int first, input logic [N:0] r,
                             input bit chk_so, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (chk_so) check("so_bit", 32'(bus.SO), 32'(r[first + i]));
            bus.SH = 1'b1;
            cycle();
            bus.SH = 1'b0;
            if (gaps) repeat ($urandom_range(0, 2)) cycle();
        end
    endtask

    task automatic do_done(input int hold);
        bus.D = 1'b1;
        repeat (hold) cycle();
        bus.D = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("rst_sum", 32'(bus.SUM), 32'h0);
        check("rst_cout", 32'(bus.COUT), 32'h0);
        check("rst_so", 32'(bus.SO), 32'h0);
        check("rst_valid", 32'(bus.VALID), 32'h0);
        check("rst_err", 32'(bus.ERR), 32'h0);
    endtask

    // Full transaction expected to complete: load, N shifts, done, result via scoreboard.
    task automatic full_txn(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub,
                            input bit gaps, input int hold);
        logic [N:0] r;
        r = ref_result(a, b, sub);
        do_load(a, b, sub, 1'b0);
        do_shifts(N, 0, r, 1'b1, gaps);
        exp_q.push_back('{sum: r[N-1:0], cout: r[N]});
        do_done(hold);
        check("txn_valid", 32'(bus.VALID), 32'h1);
        check("txn_err", 32'(bus.ERR), 32'h0);
    endtask

    // Monitor: on each VALID rise, pop the oldest expected result and compare.
    logic valid_q = 1'b0;
    always @(negedge clk) begin
        if (bus.VALID && !valid_q) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", 32'h1, 32'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_sum", 32'(bus.SUM), 32'(e.sum));
                check("sb_cout", 32'(bus.COUT), 32'(e.cout));
            end
        end
        valid_q <= bus.VALID;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N:0]   r;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         sub;
        bus.LD = 1'b0; bus.SH = 1'b0; bus.D = 1'b0;
        bus.A_IN = '0; bus.B_IN = '0;
`ifdef SERIAL_ADD_SUB_EN
        bus.SUB = 1'b0;
`endif
        repeat (2) cycle();
        do_reset();

        // Shifting before any load moves zeros only.
        do_shifts(3, 0, '0, 1'b0, 1'b0);
        check("pre_load_sum", 32'(bus.SUM), 32'h0);

        full_txn(8'h35, 8'h4A, 1'b0, 1'b0, 1);
        full_txn(8'hFF, 8'h01, 1'b0, 1'b1, 2);

        // Overrun after a completed sequence.
        bus.SH = 1'b1; cycle(); bus.SH = 1'b0;
        check("overrun_err", 32'(bus.ERR), 32'h1);
        check("overrun_sum", 32'(bus.SUM), 32'h00);
        check("overrun_cout", 32'(bus.COUT), 32'h1);
        do_load(8'h0F, 8'h01, 1'b0, 1'b0);
        check("reload_err", 32'(bus.ERR), 32'h0);
        check("reload_valid", 32'(bus.VALID), 32'h0);

        // Early done after 4 shifts.
        do_shifts(4, 0, ref_result(8'h0F, 8'h01, 1'b0), 1'b1, 1'b0);
        do_done(1);
        check("early_err", 32'(bus.ERR), 32'h1);
        check("early_valid", 32'(bus.VALID), 32'h0);

        // Reset mid-sequence.
        do_load(8'hA5, 8'h3C, 1'b0, 1'b0);
        do_shifts(3, 0, '0, 1'b0, 1'b0);
        do_reset();

        // D on the same edge as the Nth shift sees the pre-edge count.
        a = 8'h6B; b = 8'h2E;
        r = ref_result(a, b, 1'b0);
        do_load(a, b, 1'b0, 1'b0);
        do_shifts(N - 1, 0, r, 1'b1, 1'b0);
        bus.SH = 1'b1; bus.D = 1'b1; cycle(); bus.SH = 1'b0; bus.D = 1'b0;
        check("same_edge_err", 32'(bus.ERR), 32'h1);
        check("same_edge_valid", 32'(bus.VALID), 32'h0);
        check("same_edge_sum", 32'(bus.SUM), 32'(r[N-1:0]));

        // LD with SH: load wins, count restarts so exactly N more shifts complete.
        a = 8'h12; b = 8'h34;
        r = ref_result(a, b, 1'b0);
        do_load(a, b, 1'b0, 1'b1);
        do_shifts(N, 0, r, 1'b1, 1'b0);
        exp_q.push_back('{sum: r[N-1:0], cout: r[N]});
        do_done(1);
        check("collide_valid", 32'(bus.VALID), 32'h1);
        check("collide_err", 32'(bus.ERR), 32'h0);

`ifdef SERIAL_ADD_SUB_EN
        full_txn(8'h10, 8'h01, 1'b1, 1'b0, 1);
        full_txn(8'h01, 8'h02, 1'b1, 1'b0, 1);
`endif

        for (int k = 0; k < 24; k++) begin
            a = N'($urandom);
            b = N'($urandom);
`ifdef SERIAL_ADD_SUB_EN
            sub = 1'($urandom);
`else
            sub = 1'b0;
`endif
            full_txn(a, b, sub, 1'($urandom), int'($urandom_range(1, 3)));
        end

        repeat (2) cycle();
        check("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
